// File: rtl/addr8s_serial_pkg.sv
// Shared constants and state encoding for the bit-serial operand-recovery block.
package addr8s_serial_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/addr8s_serial_recover_fs_cell.sv
// One-bit full subtractor with its borrow flop; the borrow clears synchronously
// on clr_i and only advances while en_i is high.
module serial_fs_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic o_i,
  input  logic a_i,
  output logic diff_o,
  output logic borrow_q
);

  logic borrow_d;

  assign diff_o   = o_i ^ a_i ^ borrow_q;
  assign borrow_d = (~o_i & a_i) | (~(o_i ^ a_i) & borrow_q);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      borrow_q <= 1'b0;
    end else if (en_i) begin
      borrow_q <= borrow_d;
    end
  end

endmodule

// File: rtl/addr8s_serial_recover.sv
// Recovers B = O - A bit-serially, LSB first, behind valid/ready handshakes.
// Define ADDR8S_SERIAL_FAULT_DETECT_EN to add a lockstep replica cell and err_o.
module addr8s_serial_recover
  import addr8s_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_i,
  input  logic [WIDTH-1:0] a_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b_o,
  output logic             ovf_o
`ifdef ADDR8S_SERIAL_FAULT_DETECT_EN
  ,
  output logic             err_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   o_sr_q, a_sr_q, res_q, res_d;
  logic             o_sgn_q, a_sgn_q;
  logic             in_ready_q, out_valid_q, ovf_q;
  logic [WIDTH-1:0] b_q;
  logic             accept, step, diff, borrow;

  assign accept = (state_q == IDLE) && in_valid;
  assign step   = (state_q == SHIFT);
  assign res_d  = {diff, res_q[WIDTH:1]};

  serial_fs_cell u_fs (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (step),
    .o_i      (o_sr_q[0]),
    .a_i      (a_sr_q[0]),
    .diff_o   (diff),
    .borrow_q (borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      o_sr_q      <= '0;
      a_sr_q      <= '0;
      res_q       <= '0;
      o_sgn_q     <= 1'b0;
      a_sgn_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      b_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          o_sr_q     <= sum_i;
          a_sr_q     <= {a_i[WIDTH-1], a_i};
          o_sgn_q    <= sum_i[WIDTH];
          a_sgn_q    <= a_i[WIDTH-1];
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          o_sr_q <= o_sr_q >> 1;
          a_sr_q <= a_sr_q >> 1;
          res_q  <= res_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Flag both a wrapped (WIDTH+1)-bit difference and one that fits
            // in WIDTH+1 bits but not in WIDTH.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            b_q         <= res_d[WIDTH-1:0];
            ovf_q       <= ((o_sgn_q != a_sgn_q) && (res_d[WIDTH] != o_sgn_q)) ||
                           (res_d[WIDTH] != res_d[WIDTH-1]);
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign b_o       = b_q;
  assign ovf_o     = ovf_q;

`ifdef ADDR8S_SERIAL_FAULT_DETECT_EN
  logic diff_rep, borrow_rep, err_q;

  serial_fs_cell u_fs_rep (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (step),
    .o_i      (o_sr_q[0]),
    .a_i      (a_sr_q[0]),
    .diff_o   (diff_rep),
    .borrow_q (borrow_rep)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == DONE) && out_ready) begin
      err_q <= 1'b0;
    end else if (step && (diff != diff_rep)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q & out_valid_q;
`endif

endmodule
